// File: rtl/tdc_accum_if.sv
// Handshake bundle between tdc_accum and the digital back-end.
// slave is the accumulator side; master is the back-end that starts and accepts results.
interface tdc_accum_if #(
  parameter int unsigned ACC_W = 16
) ();
  logic             start;
  logic             busy;
  logic [ACC_W-1:0] result;
  logic             result_valid;
  logic             result_ready;
  logic             overflow;

  modport master (
    output start, result_ready,
    input  busy, result, result_valid, overflow
  );

  modport slave (
    input  start, result_ready,
    output busy, result, result_valid, overflow
  );
endinterface

// File: rtl/tdc_accum.sv
// Time-domain MAC back-end: counts TDC-high cycles per window and sums N_TERMS windows
// into a saturating accumulator. Define TDC_ACC_SYNC_EN to add a two-flop input synchroniser.
module tdc_accum #(
  parameter int unsigned WIN_LEN = 16,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tdc_in,
  tdc_accum_if.slave  bus
);

  localparam int unsigned TermW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

  typedef enum logic [1:0] {StIdle, StMeas, StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [TermW-1:0] term_q, term_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;
  logic             sample;

`ifdef TDC_ACC_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], tdc_in};
    end
  end

  assign sample = sync_q[1];
`else
  assign sample = tdc_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      win_q   <= '0;
      term_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      term_q  <= term_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    term_d  = term_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    // One extra bit catches the carry that triggers saturation.
    sum     = {1'b0, acc_q} + (ACC_W+1)'(cnt_q);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StMeas;
          cnt_d   = '0;
          win_d   = '0;
          term_d  = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      StMeas: begin
        if (sample) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (win_q == CNT_W'(WIN_LEN - 1)) begin
          win_d   = '0;
          state_d = StAccum;
        end else begin
          win_d = win_q + CNT_W'(1);
        end
      end
      StAccum: begin
        cnt_d = '0;
        if (sum[ACC_W]) begin
          acc_d = '1;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
        if (term_q == TermW'(N_TERMS - 1)) begin
          state_d = StDone;
        end else begin
          term_d  = term_q + TermW'(1);
          state_d = StMeas;
        end
      end
      StDone: begin
        if (bus.result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Accumulator is only cleared by an accepted start, so result holds through DONE and IDLE.
  assign bus.busy         = (state_q != StIdle);
  assign bus.result_valid = (state_q == StDone);
  assign bus.result       = acc_q;
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_tdc_accum.sv
// Directed self-checking bench for tdc_accum: default instance plus a narrow
// saturating instance (ACC_W=8, WIN_LEN=100) sharing clock, reset and tdc_in.
module tb_tdc_accum;

`ifdef TDC_ACC_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic tdc_in;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sel      = 0;
  int   edges;

  always #5 clk = ~clk;

  tdc_accum_if #(.ACC_W(16)) bus_m ();
  tdc_accum_if #(.ACC_W(8))  bus_s ();

  tdc_accum #(
    .WIN_LEN (16),
    .CNT_W   (8),
    .N_TERMS (4),
    .ACC_W   (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tdc_in (tdc_in),
    .bus    (bus_m)
  );

  tdc_accum #(
    .WIN_LEN (100),
    .CNT_W   (8),
    .N_TERMS (4),
    .ACC_W   (8)
  ) dut_sat (
    .clk    (clk),
    .rst    (rst),
    .tdc_in (tdc_in),
    .bus    (bus_s)
  );

  wire        obs_busy   = (sel != 0) ? bus_s.busy : bus_m.busy;
  wire        obs_valid  = (sel != 0) ? bus_s.result_valid : bus_m.result_valid;
  wire        obs_ovf    = (sel != 0) ? bus_s.overflow : bus_m.overflow;
  wire [15:0] obs_result = (sel != 0) ? {8'h00, bus_s.result} : bus_m.result;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Value that must be counted on edge j after the start edge (j <= 0 is before any window).
  function automatic logic pat(input int mode, input int win, input int j);
    if (j < 1) return 1'b0;
    if (mode == 1) return 1'b1;
    if (mode == 2) return (((j - 1) % (win + 1)) < 5);
    return 1'b0;
  endfunction

  // Starts an operation on the selected instance and returns edges from start to result_valid.
  task automatic run_op(input int s, input int mode, input int win, output int nedge);
    sel   = s;
    nedge = -1;
    for (int j = -2; j <= 0; j++) begin
      tdc_in = pat(mode, win, j + Lat);
      if (s != 0) bus_s.start = (j == 0);
      else        bus_m.start = (j == 0);
      tick();
    end
    bus_s.start = 1'b0;
    bus_m.start = 1'b0;
    check("busy_after_start", 32'(obs_busy), 32'd1);
    for (int j = 1; j <= 1000; j++) begin
      tdc_in = pat(mode, win, j + Lat);
      tick();
      if (obs_valid) begin
        nedge = j;
        break;
      end
    end
  endtask

  initial begin
    rst                = 1'b1;
    tdc_in             = 1'b0;
    bus_m.start        = 1'b0;
    bus_m.result_ready = 1'b0;
    bus_s.start        = 1'b0;
    bus_s.result_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(obs_busy), 32'd0);
    check("rst_valid", 32'(obs_valid), 32'd0);
    check("rst_result", 32'(obs_result), 32'd0);
    check("rst_overflow", 32'(obs_ovf), 32'd0);
    rst = 1'b0;
    tick();

    // All-ones input, ready held high beforehand
    bus_m.result_ready = 1'b1;
    run_op(0, 1, 16, edges);
    check("ones_latency", 32'(edges), 32'd68);
    check("ones_result", 32'(obs_result), 32'd64);
    check("ones_overflow", 32'(obs_ovf), 32'd0);
    tick();
    check("ones_valid_fall", 32'(obs_valid), 32'd0);
    check("ones_busy_fall", 32'(obs_busy), 32'd0);
    check("ones_result_hold", 32'(obs_result), 32'd64);

    // Five high cycles at the start of each window
    run_op(0, 2, 16, edges);
    check("pat5_latency", 32'(edges), 32'd68);
    check("pat5_result", 32'(obs_result), 32'd20);
    check("pat5_overflow", 32'(obs_ovf), 32'd0);
    tick();

    // Saturation on the narrow instance, then a new start clears overflow
    bus_s.result_ready = 1'b1;
    run_op(1, 1, 100, edges);
    check("sat_latency", 32'(edges), 32'd404);
    check("sat_result", 32'(obs_result), 32'd255);
    check("sat_overflow", 32'(obs_ovf), 32'd1);
    tick();
    check("sat_overflow_sticky", 32'(obs_ovf), 32'd1);
    bus_s.start = 1'b1;
    tick();
    bus_s.start = 1'b0;
    check("sat_overflow_cleared", 32'(obs_ovf), 32'd0);
    check("sat_restart_busy", 32'(obs_busy), 32'd1);
    sel = 0;

    // Consumer stalls in DONE while start pulses arrive
    bus_m.result_ready = 1'b0;
    run_op(0, 1, 16, edges);
    check("hold_latency", 32'(edges), 32'd68);
    for (int i = 0; i < 10; i++) begin
      bus_m.start = (i % 2 == 0);
      tick();
      check("hold_valid", 32'(obs_valid), 32'd1);
      check("hold_result", 32'(obs_result), 32'd64);
      check("hold_busy", 32'(obs_busy), 32'd1);
    end
    bus_m.start        = 1'b1;
    bus_m.result_ready = 1'b1;
    tick();
    bus_m.start = 1'b0;
    check("accept_valid_fall", 32'(obs_valid), 32'd0);
    check("accept_busy_fall", 32'(obs_busy), 32'd0);
    tick();
    check("start_ignored_on_accept", 32'(obs_busy), 32'd0);

    // Reset on the 7th sample of term 2 (edge e41)
    tdc_in = 1'b1;
    tick();
    tick();
    bus_m.start = 1'b1;
    tick();
    bus_m.start = 1'b0;
    repeat (40) tick();
    check("mid_acc_two_terms", 32'(obs_result), 32'd32);
    check("mid_busy", 32'(obs_busy), 32'd1);
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(obs_busy), 32'd0);
    check("midrst_valid", 32'(obs_valid), 32'd0);
    check("midrst_result", 32'(obs_result), 32'd0);
    check("midrst_overflow", 32'(obs_ovf), 32'd0);
    rst = 1'b0;
    tick();
    run_op(0, 0, 16, edges);
    check("zeros_latency", 32'(edges), 32'd68);
    check("zeros_result", 32'(obs_result), 32'd0);
    check("zeros_overflow", 32'(obs_ovf), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_accum.md
# tdc_accum

Downstream consumer of the 1-bit TDC output in the time-domain MAC datapath. Over a fixed measurement window it counts the clock cycles in which the TDC output is high, converting one time-encoded product into a digital value. It sums N_TERMS consecutive products into a saturating accumulator. The MAC result is presented to the digital back-end through a valid/ready handshake.

## Interface
- WIN_LEN, 16: cycles per measurement window (one product term); 1 ≤ WIN_LEN ≤ 2^CNT_W−1.
- CNT_W, 8: width of the per-window counter.
- N_TERMS, 4: products summed per MAC operation; ≥ 1.
- ACC_W, 16: accumulator/result width; ACC_W ≥ CNT_W.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a MAC operation; honoured only in IDLE.
- tdc_in  in  1  TDC output bit (the TDC `out` port).
- busy  out  1  high in MEAS, ACCUM and DONE.
- result  out  ACC_W  accumulated MAC value.
- result_valid  out  1  result available; high only in DONE.
- result_ready  in  1  consumer accepts result.
- overflow  out  1  sticky flag: the accumulator saturated during the current or last operation.

## Operation
- States: IDLE, MEAS, ACCUM, DONE.
- IDLE:
  - start=1 → MEAS.
  - On that same edge: clear the counter, accumulator, term index and overflow.
  - start=0 → stay in IDLE.
- MEAS:
  - Sample the (optionally synchronised) tdc_in on exactly WIN_LEN edges.
  - Increment the counter on each sample that is 1.
  - After the WIN_LEN-th sample → ACCUM.
- ACCUM (one cycle):
  - acc ← acc + count, saturating at 2^ACC_W−1.
  - Saturation sets overflow.
  - Clear the counter.
  - If term index = N_TERMS−1 → DONE; otherwise increment the index → MEAS.
- DONE:
  - result_valid=1; result holds the accumulator value.
  - result_ready=1 → IDLE next edge.
  - result and overflow keep their values until the next accepted start.
- start is ignored outside IDLE, including the DONE→IDLE handshake cycle.
- The counter cannot overflow: WIN_LEN ≤ 2^CNT_W−1 is a parameter legality rule. An illegal value is a configuration error with no defined behaviour.
- rst at any time, including mid-window: next state IDLE. All internal registers and the synchroniser clear.

## Timing
- Reset values: busy=0, result=0, result_valid=0, overflow=0; state IDLE.
- Let e0 be the edge sampling start=1.
  - busy rises after e0.
  - Term k is sampled on edges e(k·(WIN_LEN+1)+1) … e(k·(WIN_LEN+1)+WIN_LEN).
  - Term k's ACCUM edge is e((k+1)·(WIN_LEN+1)).
- result_valid rises after edge e(N_TERMS·(WIN_LEN+1)). With defaults that is 68 edges after e0.
- result_valid stays high until the edge on which result_ready=1. It falls, and busy falls, after that edge.
- result_ready asserted before result_valid has no effect.
- The result is stable throughout the time result_valid is high.

## Configuration
- TDC_ACC_SYNC_EN defined:
  - tdc_in passes through a two-flop synchroniser (reset to 0) before the counter.
  - The sample taken on edge e is the tdc_in value sampled at e−2.
  - Control latency and handshake timing are unchanged.
- TDC_ACC_SYNC_EN undefined: tdc_in feeds the counter directly, with zero added delay.

## Test plan
- Reset checks:
  - rst=1 for 2 cycles → all outputs 0, busy=0.
  - start pulse with tdc_in held 1, defaults, result_ready=1 → result_valid after 68 edges, result=64, overflow=0.
- tdc_in pattern: high for the first 5 cycles of each window, low otherwise; N_TERMS=4 → result=20. Repeat with TDC_ACC_SYNC_EN defined and tdc_in shifted 2 cycles earlier → result=20.
- ACC_W=8, WIN_LEN=100, tdc_in=1, N_TERMS=4 → result=255, overflow=1. A next start clears overflow.
- result_ready held 0 for 10 cycles in DONE → result_valid stays 1, result stable, start pulses ignored. Then ready=1 → IDLE next edge.
- rst asserted at the 7th sample of term 2 → IDLE next edge, outputs zero. A new start with tdc_in=0 → result=0.
